calc_seq: RTL
=============

# calc_seq

Operation sequencer for the 16-bit calculator datapath. It captures entered operands and operator codes and launches the multi-cycle ALU. It owns the accumulator and operand registers. It drives the select and load strobe of the 16-bit 2:1 result mux (mpx16_2_1), so the accumulator loads either a freshly entered number or the ALU result. It sits between the input decoder and the ALU/display path.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in WAIT_ALU before the error state; legal range 1..255; 8-bit counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  user clear; synchronous; same effect as rst.
- num_in  in  16  entered number.
- num_valid  in  1  one-cycle strobe, num_in valid.
- op_in  in  2  operator code, passed through to the ALU uninterpreted.
- op_valid  in  1  one-cycle strobe, op_in valid.
- acc_d  in  16  mux output: l0 = opnd, l1 = alu_result, s = mpx_sel.
- alu_done  in  1  ALU result valid for one cycle.
- alu_err  in  1  qualifies alu_done; the result is invalid (e.g. divide by zero).
- mpx_sel  out  1  mux select: 0 = operand, 1 = ALU result.
- opnd  out  16  operand register, drives mux l0 and ALU b input.
- acc  out  16  accumulator register, drives ALU a input and display.
- alu_op  out  2  latched operator.
- alu_start  out  1  one-cycle ALU launch pulse.
- busy  out  1  high in LOAD, EXEC and WAIT_ALU.
- err  out  1  high in ERR.

## Operation
- States: IDLE, LOAD, HAVE_A, WAIT_B, EXEC, WAIT_ALU, ERR.
- IDLE:
  - num_valid: opnd <= num_in; go to LOAD.
  - op_valid is ignored.
- LOAD:
  - mpx_sel = 0, acc_load = 1, so acc <= acc_d (which equals opnd).
  - Go to HAVE_A.
- HAVE_A:
  - op_valid: alu_op <= op_in; go to WAIT_B.
  - num_valid (without op_valid): opnd <= num_in; go to LOAD (replaces A).
  - If both strobes arrive together, op_valid wins and num_valid is dropped.
- WAIT_B:
  - num_valid: opnd <= num_in; go to EXEC.
  - op_valid alone: alu_op <= op_in; stay in WAIT_B.
  - If both strobes arrive together, num_valid wins.
- EXEC: alu_start = 1; clear the timeout counter; go to WAIT_ALU.
- WAIT_ALU: mpx_sel = 1; the counter increments each cycle.
  - alu_done && !alu_err: acc_load = 1, so acc <= acc_d (the ALU result); go to HAVE_A.
  - alu_done && alu_err: go to ERR; acc is unchanged.
  - Counter reaches TIMEOUT-1 with no alu_done: go to ERR.
  - alu_done on that same last cycle takes priority over the timeout.
- ERR: only clr or rst exits; num_valid and op_valid are ignored.
- Input strobes arriving in LOAD, EXEC or WAIT_ALU are dropped; there is no queuing.
- alu_done outside WAIT_ALU is ignored.
- rst or clr in any state has highest priority: go to IDLE with acc = 0, opnd = 0, alu_op = 0, counter = 0.
  - A pending alu_done in the same cycle is discarded.
- acc_load is internal only. mpx_sel is 0 in every state except WAIT_ALU.

## Timing
- Reset values: mpx_sel 0, alu_start 0, busy 0, err 0, acc 16'h0000, opnd 16'h0000, alu_op 2'b00. State is IDLE.
- mpx_sel, alu_start, busy and err are Moore decodes of state; they are glitch-free relative to clk.
- Operand A: num_valid at cycle n, then LOAD at n+1, then acc valid and state HAVE_A at n+2.
- Operand B: num_valid at cycle n in WAIT_B, then alu_start high at n+1, then WAIT_ALU from n+2.
- Result: alu_done at cycle m (m ≥ n+2), then acc updated and state HAVE_A at m+1. busy falls at m+1.
- Timeout: ERR is entered after exactly TIMEOUT cycles in WAIT_ALU.
- alu_start is never high for two consecutive cycles.
- acc changes only on a LOAD or WAIT_ALU completion edge, or on rst/clr.

## Test plan
- Add chain: enter 16'h0005, op 00, 16'h0003; ALU model returns 16'h0008 after 4 cycles. Required: alu_start is a single pulse with acc = 5 and opnd = 3; acc = 16'h0008 one cycle after alu_done; state HAVE_A.
- Chained op: from acc = 8, op 01, enter 16'h0002; ALU returns 16'h0006. Required: acc = 6, and no LOAD occurs between the two operations.
- Divide error: op 11, B = 0; alu_done with alu_err. Required: err = 1, acc unchanged. num_valid is ignored; clr returns to IDLE with acc = 0 and err = 0.
- Timeout: TIMEOUT = 8, ALU never responds. Required: err rises exactly 8 cycles after entering WAIT_ALU. A second run with alu_done on the 8th cycle must end in HAVE_A with no error.
- Strobe rules: assert num_valid and op_valid together in HAVE_A, then again in WAIT_B. Required: the op is taken in HAVE_A and the number is taken in WAIT_B. A num_valid during WAIT_ALU must leave opnd unchanged.
- Reset mid-operation: assert rst in WAIT_ALU in the same cycle as alu_done. Required: next cycle IDLE with all outputs at reset values; acc = 0, not the ALU result.

Source files
------------

// File: rtl/calc_seq.sv
// Operation sequencer for the 16-bit calculator: captures operands and operators,
// launches the multi-cycle ALU and steers the accumulator load mux.
module calc_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] num_in,
  input  logic        num_valid,
  input  logic [1:0]  op_in,
  input  logic        op_valid,
  input  logic [15:0] acc_d,
  input  logic        alu_done,
  input  logic        alu_err,
  output logic        mpx_sel,
  output logic [15:0] opnd,
  output logic [15:0] acc,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_HAVE_A   = 3'd2;
  localparam logic [2:0] S_WAIT_B   = 3'd3;
  localparam logic [2:0] S_EXEC     = 3'd4;
  localparam logic [2:0] S_WAIT_ALU = 3'd5;
  localparam logic [2:0] S_ERR      = 3'd6;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] opnd_q, opnd_d;
  logic [15:0] acc_reg_q, acc_reg_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        acc_load_s;
  logic        mpx_sel_q, mpx_sel_d;
  logic        alu_start_q, alu_start_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  // Next-state, operand/operator capture and timeout counter.
  always_comb begin
    state_d    = state_q;
    opnd_d     = opnd_q;
    alu_op_d   = alu_op_q;
    cnt_d      = cnt_q;
    acc_load_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (num_valid) begin
          opnd_d  = num_in;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        acc_load_s = 1'b1;
        state_d    = S_HAVE_A;
      end
      S_HAVE_A: begin
        if (op_valid) begin
          alu_op_d = op_in;
          state_d  = S_WAIT_B;
        end else if (num_valid) begin
          opnd_d  = num_in;
          state_d = S_LOAD;
        end else begin
          state_d = S_HAVE_A;
        end
      end
      S_WAIT_B: begin
        if (num_valid) begin
          opnd_d  = num_in;
          state_d = S_EXEC;
        end else if (op_valid) begin
          alu_op_d = op_in;
          state_d  = S_WAIT_B;
        end else begin
          state_d = S_WAIT_B;
        end
      end
      S_EXEC: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT_ALU;
      end
      S_WAIT_ALU: begin
        cnt_d = cnt_q + 8'd1;
        // A completion on the final counted cycle still wins over the timeout.
        if (alu_done && !alu_err) begin
          acc_load_s = 1'b1;
          state_d    = S_HAVE_A;
        end else if (alu_done) begin
          state_d = S_ERR;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          state_d = S_WAIT_ALU;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Accumulator load from the external result mux.
  always_comb begin
    if (acc_load_s) begin
      acc_reg_d = acc_d;
    end else begin
      acc_reg_d = acc_reg_q;
    end
  end

  // Moore output decodes taken from the next state so the outputs leave a flop.
  always_comb begin
    mpx_sel_d   = (state_d == S_WAIT_ALU);
    alu_start_d = (state_d == S_EXEC);
    busy_d      = (state_d == S_LOAD) || (state_d == S_EXEC) || (state_d == S_WAIT_ALU);
    err_d       = (state_d == S_ERR);
  end

  // State and datapath registers; rst and clr both force the idle state.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q     <= S_IDLE;
      opnd_q      <= 16'h0000;
      acc_reg_q   <= 16'h0000;
      alu_op_q    <= 2'b00;
      cnt_q       <= 8'd0;
      mpx_sel_q   <= 1'b0;
      alu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      acc_reg_q   <= acc_reg_d;
      alu_op_q    <= alu_op_d;
      cnt_q       <= cnt_d;
      mpx_sel_q   <= mpx_sel_d;
      alu_start_q <= alu_start_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign mpx_sel   = mpx_sel_q;
  assign opnd      = opnd_q;
  assign acc       = acc_reg_q;
  assign alu_op    = alu_op_q;
  assign alu_start = alu_start_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
